matmul_stream_param: RTL and testbench

- Parametrised successor to the fixed 3x3 8-bit array multiplier.
- Computes C = A x B for NxN matrices of DW-bit elements, in signed or unsigned mode.
- Operands arrive as a valid/ready element stream. Results leave as a valid/ready stream with backpressure.
- Returns to LOAD after each result instead of parking in a terminal state, so it sits behind the top-level pin mux and processes back-to-back jobs.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_mac.sv | 42 ++++
 rtl/matmul_stream_param.sv | 179 +++++++++++++++++
 tb/tb_matmul_stream_param.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the streaming NxN matrix multiplier: FSM encoding,
// result-width helper and row-major flat addressing.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // Result width that cannot overflow: a full product plus log2(N) carry bits.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Row-major flat index of element [row][col] in an n x n matrix.
    function automatic int idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate lane: DW x DW product (signed or unsigned),
// accumulated into an ACCW register that restarts on the first term of a dot product.
module matmul_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            mode_signed,
    input  logic            en,
    input  logic            first,
    output logic [ACCW-1:0] acc_next
);

    logic [ACCW-1:0] a_ext;
    logic [ACCW-1:0] b_ext;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;

    // Extend both operands to ACCW bits; the low ACCW bits of the product are then
    // the exact two's-complement result because the true value always fits.
    always_comb begin
        a_ext    = mode_signed ? {{(ACCW-DW){a[DW-1]}}, a} : {{(ACCW-DW){1'b0}}, a};
        b_ext    = mode_signed ? {{(ACCW-DW){b[DW-1]}}, b} : {{(ACCW-DW){1'b0}}, b};
        prod     = a_ext * b_ext;
        acc_next = first ? prod : acc_q + prod;
        acc_d    = en ? acc_next : acc_q;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_stream_param.sv
// Streaming C = A x B for NxN matrices: load A then B row-major, run N^3 MAC
// cycles, then stream C row-major with backpressure and return to LOAD.
module matmul_stream_param
    import matmul_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int DW   = 8,
    localparam int ACCW = acc_width(N, DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            mode_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int NN    = N * N;
    localparam int LOADS = 2 * NN;
    localparam int IW    = $clog2(N);
    localparam int AW    = $clog2(NN);
    localparam int LW    = $clog2(LOADS);

    state_t          state_q, state_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [IW-1:0]   k_q, k_d;
    logic [AW-1:0]   out_cnt_q, out_cnt_d;
    logic            mode_q, mode_d;

    logic            in_hs;
    logic            out_hs;
    logic            load_done;
    logic            k_last;
    logic            compute_done;
    logic            out_done;

    logic            a_we, b_we, c_we;
    logic [AW-1:0]   load_addr;
    logic [AW-1:0]   a_rd_addr;
    logic [AW-1:0]   b_rd_addr;
    logic [AW-1:0]   c_wr_addr;
    logic [ACCW-1:0] mac_acc_next;

    // Matrix storage; contents are don't-care after reset.
    logic [DW-1:0]   a_mem [0:NN-1];
    logic [DW-1:0]   b_mem [0:NN-1];
    logic [ACCW-1:0] c_mem [0:NN-1];

    // Handshakes, loop-end conditions and memory addressing.
    always_comb begin
        in_hs        = in_valid && in_ready;
        out_hs       = out_valid && out_ready;
        load_done    = in_hs && (load_cnt_q == LW'(LOADS - 1));
        k_last       = (k_q == IW'(N - 1));
        compute_done = (state_q == COMPUTE) && k_last &&
                       (j_q == IW'(N - 1)) && (i_q == IW'(N - 1));
        out_done     = out_hs && (out_cnt_q == AW'(NN - 1));

        load_addr = (load_cnt_q < LW'(NN)) ? AW'(load_cnt_q) : AW'(load_cnt_q - LW'(NN));
        a_we      = !rst && in_hs && (load_cnt_q < LW'(NN));
        b_we      = !rst && in_hs && (load_cnt_q >= LW'(NN));
        a_rd_addr = AW'(idx(int'(i_q), int'(k_q), N));
        b_rd_addr = AW'(idx(int'(k_q), int'(j_q), N));
        c_wr_addr = AW'(idx(int'(i_q), int'(j_q), N));
        c_we      = !rst && (state_q == COMPUTE) && k_last;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD -> COMPUTE -> OUTPUT -> LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_done)    state_d = COMPUTE;
            COMPUTE: if (compute_done) state_d = OUTPUT;
            OUTPUT:  if (out_done)     state_d = LOAD;
            default:                   state_d = LOAD;
        endcase
    end

    // FSM outputs; out_data is forced to zero outside OUTPUT.
    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUTPUT);
        busy      = (state_q != LOAD);
        out_last  = out_valid && (out_cnt_q == AW'(NN - 1));
        out_data  = out_valid ? c_mem[out_cnt_q] : '0;
    end

    // Counter and mode updates; i/j/k wrap to zero at the end of COMPUTE.
    always_comb begin
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        out_cnt_d  = out_cnt_q;
        mode_d     = mode_q;
        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    load_cnt_d = load_done ? '0 : load_cnt_q + LW'(1);
                    if (load_cnt_q == '0) mode_d = mode_signed;
                end
            end
            COMPUTE: begin
                if (k_last) begin
                    k_d = '0;
                    if (j_q == IW'(N - 1)) begin
                        j_d = '0;
                        i_d = (i_q == IW'(N - 1)) ? '0 : i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            OUTPUT: begin
                if (out_hs) out_cnt_d = out_done ? '0 : out_cnt_q + AW'(1);
            end
            default: ;
        endcase
    end

    // Counter and mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            out_cnt_q  <= '0;
            mode_q     <= 1'b0;
        end else begin
            load_cnt_q <= load_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            out_cnt_q  <= out_cnt_d;
            mode_q     <= mode_d;
        end
    end

    // Operand and result storage writes.
    always_ff @(posedge clk) begin
        if (a_we) a_mem[load_addr] <= in_data;
        if (b_we) b_mem[load_addr] <= in_data;
        if (c_we) c_mem[c_wr_addr] <= mac_acc_next;
    end

    matmul_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .a           (a_mem[a_rd_addr]),
        .b           (b_mem[b_rd_addr]),
        .mode_signed (mode_q),
        .en          (state_q == COMPUTE),
        .first       (k_q == '0),
        .acc_next    (mac_acc_next)
    );

endmodule

// File: tb/tb_matmul_stream_param.sv
// Directed bench for matmul_stream_param at N=3, DW=8 (18-bit results).
module tb_matmul_stream_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mode_signed;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        out_last;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]  va [9];
    logic [7:0]  vb [9];
    logic [17:0] exp_data [9];
    logic [17:0] got_data [9];
    logic        got_last [9];

    matmul_stream_param #(.N(3), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode_signed (mode_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stream A then B; mode_signed is driven inverted after element 0 so a
    // design that keeps sampling it would corrupt the result.
    task automatic push_job(input logic ms);
        for (int e = 0; e < 18; e++) begin
            int guard = 0;
            in_valid    = 1'b1;
            in_data     = (e < 9) ? va[e] : vb[e-9];
            mode_signed = (e == 0) ? ms : ~ms;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                total_cnt++;
                $display("FAIL push_timeout: element %0d in_ready=%b required 1", e, in_ready);
            end
            @(negedge clk);
        end
        in_valid    = 1'b0;
        mode_signed = 1'b0;
    endtask

    // Cycles from the last input handshake cycle until out_valid is seen.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            total_cnt++;
            $display("FAIL valid_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    // Accept all nine results with out_ready held high.
    task automatic collect();
        out_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            int guard = 0;
            while (!out_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!out_valid) begin
                total_cnt++;
                $display("FAIL collect_timeout: beat %0d out_valid=%b required 1", e, out_valid);
            end
            got_data[e] = out_data;
            got_last[e] = out_last;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 18'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_identity();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
            vb[e] = 8'(e + 1);
            exp_data[e] = 18'(e + 1);
        end
        push_job(1'b0);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL identity_compute_flags: in_ready=%b busy=%b expected 0/1", in_ready, busy);
        else pass_cnt++;
        wait_valid(lat);
        total_cnt++;
        if (lat !== 28) $display("FAIL identity_latency: got %0d expected 28", lat);
        else pass_cnt++;
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== exp_data[e])
                $display("FAIL identity_data[%0d]: got %0d expected %0d", e, got_data[e], exp_data[e]);
            else pass_cnt++;
            total_cnt++;
            if (got_last[e] !== (e == 8))
                $display("FAIL identity_last[%0d]: got %b expected %b", e, got_last[e], (e == 8));
            else pass_cnt++;
        end
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL identity_back_to_load: in_ready=%b busy=%b expected 1/0", in_ready, busy);
        else pass_cnt++;
        $display("identity: latency %0d cycles", lat);
    endtask

    task automatic test_general();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'(e + 1);
            vb[e] = 8'(e + 1);
        end
        exp_data = '{18'd30, 18'd36, 18'd42, 18'd66, 18'd81, 18'd96, 18'd102, 18'd126, 18'd150};
        push_job(1'b0);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== exp_data[e])
                $display("FAIL general_data[%0d]: got %0d expected %0d", e, got_data[e], exp_data[e]);
            else pass_cnt++;
        end
        $display("general: A x A with A=1..9 done");
    endtask

    task automatic test_unsigned_max();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'hFF;
            vb[e] = 8'hFF;
        end
        push_job(1'b0);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== 18'h2FA03)
                $display("FAIL unsigned_max[%0d]: got 0x%0h expected 0x2fa03", e, got_data[e]);
            else pass_cnt++;
        end
        $display("unsigned_max: done");
    endtask

    task automatic test_signed_extremes();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'h80;
            vb[e] = 8'h7F;
        end
        push_job(1'b1);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== 18'h34180)
                $display("FAIL signed_neg[%0d]: got 0x%0h expected 0x34180", e, got_data[e]);
            else pass_cnt++;
        end
        $display("signed_extremes: -128 x 127 done");
    endtask

    task automatic test_backpressure();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'(e + 1);
            vb[e] = 8'(e + 1);
        end
        exp_data = '{18'd30, 18'd36, 18'd42, 18'd66, 18'd81, 18'd96, 18'd102, 18'd126, 18'd150};
        push_job(1'b0);
        wait_valid(lat);
        out_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            int guard = 0;
            while (!out_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (e == 4) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 8'hA5;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    total_cnt++;
                    if (out_valid !== 1'b1 || out_data !== exp_data[4] || out_last !== 1'b0)
                        $display("FAIL stall_hold[%0d]: valid=%b data=%0d last=%b expected 1/%0d/0",
                                 s, out_valid, out_data, out_last, exp_data[4]);
                    else pass_cnt++;
                    total_cnt++;
                    if (in_ready !== 1'b0)
                        $display("FAIL stall_in_ready[%0d]: got %b expected 0", s, in_ready);
                    else pass_cnt++;
                end
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            total_cnt++;
            if (out_data !== exp_data[e] || out_last !== (e == 8))
                $display("FAIL bp_data[%0d]: got %0d last %b expected %0d last %b",
                         e, out_data, out_last, exp_data[e], (e == 8));
            else pass_cnt++;
            @(negedge clk);
        end
        $display("backpressure: 5-cycle stall on beat 4 done");
    endtask

    task automatic test_mid_reset();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'(e + 1);
            vb[e] = 8'(e + 1);
        end
        push_job(1'b0);
        repeat (9) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midreset_pre_busy: got %b expected 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_flags: in_ready=%b out_valid=%b busy=%b expected 1/0/0",
                     in_ready, out_valid, busy);
        else pass_cnt++;
        rst = 1'b0;
        for (int e = 0; e < 9; e++) begin
            va[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
            vb[e] = 8'(9 - e);
            exp_data[e] = 18'(9 - e);
        end
        push_job(1'b0);
        wait_valid(lat);
        total_cnt++;
        if (lat !== 28) $display("FAIL midreset_latency: got %0d expected 28", lat);
        else pass_cnt++;
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== exp_data[e] || got_last[e] !== (e == 8))
                $display("FAIL midreset_data[%0d]: got %0d last %b expected %0d last %b",
                         e, got_data[e], got_last[e], exp_data[e], (e == 8));
            else pass_cnt++;
        end
        $display("mid_reset: fresh job after abort done");
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'h80;
            vb[e] = 8'h80;
        end
        push_job(1'b1);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== 18'd49152)
                $display("FAIL b2b_signed[%0d]: got %0d expected 49152", e, got_data[e]);
            else pass_cnt++;
        end
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_last: got %b expected 1", in_ready);
        else pass_cnt++;
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'd2;
            vb[e] = 8'd2;
        end
        push_job(1'b0);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== 18'd12 || got_last[e] !== (e == 8))
                $display("FAIL b2b_twos[%0d]: got %0d last %b expected 12 last %b",
                         e, got_data[e], got_last[e], (e == 8));
            else pass_cnt++;
        end
        for (int e = 0; e < 9; e++) begin
            va[e] = 8'h80;
            vb[e] = 8'h7F;
        end
        push_job(1'b0);
        wait_valid(lat);
        collect();
        for (int e = 0; e < 9; e++) begin
            total_cnt++;
            if (got_data[e] !== 18'd48768)
                $display("FAIL b2b_unsigned[%0d]: got %0d expected 48768", e, got_data[e]);
            else pass_cnt++;
        end
        $display("back_to_back: three consecutive jobs done");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_general();
        test_unsigned_max();
        test_signed_extremes();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
